// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Walks BCD digits with a dead-time gap per slot, frame-coherent loads, zero blanking and blink.
module seg7_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned DEAD_CYC     = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [3:0]            bin_out,
  output logic                  dec_en,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {StOff, StBlank, StOn} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pending_q, pending_d;
  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [FC_W-1:0]       fc_q, fc_d;
  logic                  phase_q, phase_d;

  logic [3:0]            bin_d;
  logic                  dec_en_d;
  logic [N_DIGITS-1:0]   an_d;
  logic                  tick_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    active_d  = active_q;
    fc_d      = fc_q;
    phase_d   = phase_q;
    tick_d    = 1'b0;
    pending_d = load ? value_in : pending_q;

    unique case (state_q)
      StOff: begin
        state_d  = StBlank;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = pending_q;
      end
      StBlank: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEAD_LAST) state_d = StOn;
      end
      StOn: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = StBlank;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: the old pending is taken even if a load lands on this edge.
            idx_d    = '0;
            active_d = pending_q;
            tick_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StOff;
    endcase

    if (tick_d) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end

    if (!enable) begin
      state_d  = StOff;
      cnt_d    = '0;
      idx_d    = '0;
      fc_d     = '0;
      phase_d  = 1'b0;
      tick_d   = 1'b0;
      active_d = active_q;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  logic [N_DIGITS-1:0] zero_above;
  logic                hi_zero;
  logic                suppress;
  logic                lit;

  always_comb begin
    zero_above = '0;
    hi_zero    = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      hi_zero       = hi_zero & (active_d[4*i +: 4] == 4'h0);
      zero_above[i] = hi_zero;
    end
    suppress = (blank_lz && (idx_d != '0) && zero_above[idx_d]) ||
               (blink_mask[idx_d] && phase_d);
    lit      = (state_d == StOn) && !suppress;

    an_d = '1;
    if (lit) an_d[idx_d] = 1'b0;
    dec_en_d = lit;
    bin_d    = (state_d == StOff) ? 4'h0 : active_d[4*idx_d +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      idx_q      <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      fc_q       <= '0;
      phase_q    <= 1'b0;
      bin_out    <= 4'h0;
      dec_en     <= 1'b0;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      fc_q       <= fc_d;
      phase_q    <= phase_d;
      bin_out    <= bin_d;
      dec_en     <= dec_en_d;
      an_out     <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected per-cycle outputs are queued from the
// slot/frame structure and popped one per clock edge.
module tb_seg7_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned DC = 2;
  localparam int unsigned BF = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [4*N-1:0] value_in;
  logic          blank_lz;
  logic [N-1:0]  blink_mask;
  logic [3:0]    bin_out;
  logic          dec_en;
  logic [N-1:0]  an_out;
  logic          frame_tick;

  typedef struct {
    logic [N-1:0] an;
    logic         en;
    logic [3:0]   bin;
    logic         tick;
    bit           chk_bin;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  seg7_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .DEAD_CYC    (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .value_in  (value_in),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .bin_out   (bin_out),
    .dec_en    (dec_en),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic push_entry(input logic [N-1:0] an, input logic en, input logic [3:0] bin,
                            input logic tick, input bit chk_bin);
    exp_t x;
    x.an = an; x.en = en; x.bin = bin; x.tick = tick; x.chk_bin = chk_bin;
    exp_q.push_back(x);
  endtask

  task automatic push_slot(input int d, input logic [3:0] bin, input bit lit, input bit tick);
    logic [N-1:0] sel;
    sel = ~(N'(1) << d);
    for (int c = 0; c < RD; c++) begin
      if (c >= DC && lit) push_entry(sel, 1'b1, bin, 1'b0, 1'b1);
      else push_entry('1, 1'b0, bin, (c == 0) && tick, 1'b1);
    end
  endtask

  task automatic push_frame(input logic [4*N-1:0] v, input bit lz, input logic [N-1:0] mask,
                            input bit phase, input bit tick);
    logic [3:0] nib;
    bit         sup;
    for (int d = 0; d < N; d++) begin
      nib = v[4*d +: 4];
      sup = (lz && d != 0 && (v >> (4*d)) == 0) || (mask[d] && phase);
      push_slot(d, nib, !sup, tick && d == 0);
    end
  endtask

  // Parks the display in OFF with v pending; the following edge re-enters digit 0 BLANK.
  task automatic start_display(input logic [4*N-1:0] v);
    enable = 1'b0; load = 1'b1; value_in = v;
    @(posedge clk); #1;
    load = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; value_in = '0; blank_lz = 1'b0; blink_mask = '0;
    push_entry('1, 1'b0, 4'h0, 1'b0, 1'b1);
    push_entry('1, 1'b0, 4'h0, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
        miscompares++;
        $display("FAIL reset got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    load = 1'b1; value_in = 16'h1234;
    @(posedge clk); #1;
    load = 1'b0; enable = 1'b1;
    push_frame(16'h1234, 1'b0, '0, 1'b0, 1'b0);
    push_frame(16'h1234, 1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
        miscompares++;
        $display("FAIL scan c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
    end
  endtask

  task automatic test_coherent_load();
    push_frame(16'h1234, 1'b0, '0, 1'b0, 1'b1);
    push_frame(16'h5678, 1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
        miscompares++;
        $display("FAIL coherent_load c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
      if (c == 18) begin load = 1'b1; value_in = 16'h5678; end
      if (c == 19) load = 1'b0;
    end
  endtask

  task automatic test_lz();
    logic [4*N-1:0] vals[2];
    vals[0] = 16'h0040;
    vals[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_display(vals[k]);
      push_frame(vals[k], 1'b1, '0, 1'b0, 1'b0);
      for (int c = 0; exp_q.size() != 0; c++) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        vectors++;
        if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
          miscompares++;
          $display("FAIL lz v=%h c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                   vals[k], c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001;
    start_display(16'h1234);
    for (int f = 0; f < 6; f++) push_frame(16'h1234, 1'b0, 4'b0001, (f == 2 || f == 3), f != 0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
        miscompares++;
        $display("FAIL blink c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_enable_drop();
    start_display(16'h1234);
    push_slot(0, 4'h4, 1'b1, 1'b0);
    push_entry('1, 1'b0, 4'h3, 1'b0, 1'b1);
    push_entry('1, 1'b0, 4'h3, 1'b0, 1'b1);
    push_entry(4'b1101, 1'b1, 4'h3, 1'b0, 1'b1);
    push_entry(4'b1101, 1'b1, 4'h3, 1'b0, 1'b1);
    push_entry('1, 1'b0, 4'h0, 1'b0, 1'b0);
    push_entry('1, 1'b0, 4'h0, 1'b0, 1'b0);
    push_frame(16'h1234, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || frame_tick !== e.tick ||
          (e.chk_bin && bin_out !== e.bin)) begin
        miscompares++;
        $display("FAIL enable_drop c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
      if (c == 11) enable = 1'b0;
      if (c == 13) enable = 1'b1;
    end
  endtask

  task automatic test_reset_mid_frame();
    start_display(16'h1234);
    push_slot(0, 4'h4, 1'b1, 1'b0);
    push_entry('1, 1'b0, 4'h3, 1'b0, 1'b1);
    push_entry('1, 1'b0, 4'h3, 1'b0, 1'b1);
    push_entry(4'b1101, 1'b1, 4'h3, 1'b0, 1'b1);
    push_entry('1, 1'b0, 4'h0, 1'b0, 1'b1);
    // Pending must still be zero after reset, so digit 0 comes back showing 0.
    push_slot(0, 4'h0, 1'b1, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (an_out !== e.an || dec_en !== e.en || bin_out !== e.bin || frame_tick !== e.tick) begin
        miscompares++;
        $display("FAIL reset_mid_frame c=%0d got an=%b en=%b bin=%h tick=%b exp an=%b en=%b bin=%h tick=%b",
                 c, an_out, dec_en, bin_out, frame_tick, e.an, e.en, e.bin, e.tick);
      end
      if (c == 10) begin reset = 1'b1; load = 1'b1; value_in = 16'h9999; end
      if (c == 11) begin reset = 1'b0; load = 1'b0; end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherent_load();
    test_lz();
    test_blink();
    test_enable_drop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
